// File: rtl/pwm.sv
// Sine-modulated PWM source.
// A free-running 12-bit carrier counter (cont) defines a 4096-cycle PWM period.
// Once per period the 14-bit phase accumulator (A) advances by STEP, and the
// duty sample (amostra) is reloaded from a 64-entry sine ROM indexed by A[13:8].
// The output is high while cont < amostra.
//
// Parameters:
//   STEP   phase increment per PWM period (modulo 16384), default 256
// Ports:
//   clk    system clock, rising-edge active
//   rst_n  synchronous active-low reset
//   saida  PWM output (combinational compare of registered cont/amostra)
module pwm #(
    parameter int unsigned STEP = 256
) (
    input  logic clk,
    input  logic rst_n,
    output logic saida
);

    localparam int unsigned CNT_W = 12;
    localparam int unsigned PH_W  = 14;
    localparam int unsigned IDX_W = 6;

    localparam logic [CNT_W-1:0] SAMPLE_RST = CNT_W'(2048);

    logic [CNT_W-1:0] cont;
    logic [CNT_W-1:0] cont_d;
    logic [CNT_W-1:0] amostra;
    logic [CNT_W-1:0] amostra_d;
    logic [PH_W-1:0]  A;
    logic [PH_W-1:0]  A_d;
    logic [PH_W-1:0]  phase_next;
    logic             boundary;

    // Constant ROM: round(2048 + 2047*sin(2*pi*k/64)).
    function automatic logic [CNT_W-1:0] sine_lut(input logic [IDX_W-1:0] idx);
        sine_lut = SAMPLE_RST;
        case (idx)
            6'd0:  sine_lut = 12'd2048;
            6'd1:  sine_lut = 12'd2249;
            6'd2:  sine_lut = 12'd2447;
            6'd3:  sine_lut = 12'd2642;
            6'd4:  sine_lut = 12'd2831;
            6'd5:  sine_lut = 12'd3013;
            6'd6:  sine_lut = 12'd3185;
            6'd7:  sine_lut = 12'd3347;
            6'd8:  sine_lut = 12'd3495;
            6'd9:  sine_lut = 12'd3630;
            6'd10: sine_lut = 12'd3750;
            6'd11: sine_lut = 12'd3853;
            6'd12: sine_lut = 12'd3939;
            6'd13: sine_lut = 12'd4007;
            6'd14: sine_lut = 12'd4056;
            6'd15: sine_lut = 12'd4085;
            6'd16: sine_lut = 12'd4095;
            6'd17: sine_lut = 12'd4085;
            6'd18: sine_lut = 12'd4056;
            6'd19: sine_lut = 12'd4007;
            6'd20: sine_lut = 12'd3939;
            6'd21: sine_lut = 12'd3853;
            6'd22: sine_lut = 12'd3750;
            6'd23: sine_lut = 12'd3630;
            6'd24: sine_lut = 12'd3495;
            6'd25: sine_lut = 12'd3347;
            6'd26: sine_lut = 12'd3185;
            6'd27: sine_lut = 12'd3013;
            6'd28: sine_lut = 12'd2831;
            6'd29: sine_lut = 12'd2642;
            6'd30: sine_lut = 12'd2447;
            6'd31: sine_lut = 12'd2249;
            6'd32: sine_lut = 12'd2048;
            6'd33: sine_lut = 12'd1847;
            6'd34: sine_lut = 12'd1649;
            6'd35: sine_lut = 12'd1454;
            6'd36: sine_lut = 12'd1265;
            6'd37: sine_lut = 12'd1083;
            6'd38: sine_lut = 12'd911;
            6'd39: sine_lut = 12'd749;
            6'd40: sine_lut = 12'd601;
            6'd41: sine_lut = 12'd466;
            6'd42: sine_lut = 12'd346;
            6'd43: sine_lut = 12'd243;
            6'd44: sine_lut = 12'd157;
            6'd45: sine_lut = 12'd89;
            6'd46: sine_lut = 12'd40;
            6'd47: sine_lut = 12'd11;
            6'd48: sine_lut = 12'd1;
            6'd49: sine_lut = 12'd11;
            6'd50: sine_lut = 12'd40;
            6'd51: sine_lut = 12'd89;
            6'd52: sine_lut = 12'd157;
            6'd53: sine_lut = 12'd243;
            6'd54: sine_lut = 12'd346;
            6'd55: sine_lut = 12'd466;
            6'd56: sine_lut = 12'd601;
            6'd57: sine_lut = 12'd749;
            6'd58: sine_lut = 12'd911;
            6'd59: sine_lut = 12'd1083;
            6'd60: sine_lut = 12'd1265;
            6'd61: sine_lut = 12'd1454;
            6'd62: sine_lut = 12'd1649;
            6'd63: sine_lut = 12'd1847;
            default: sine_lut = SAMPLE_RST;
        endcase
    endfunction

    // Next-state: carrier always counts; phase and sample move only at the period boundary.
    always_comb begin
        boundary   = &cont;
        phase_next = A + PH_W'(STEP);
        cont_d     = cont + CNT_W'(1);
        A_d        = A;
        amostra_d  = amostra;
        if (boundary) begin
            A_d       = phase_next;
            // Sample is taken from the advanced phase so it is live at cont = 0.
            amostra_d = sine_lut(phase_next[PH_W-1:PH_W-IDX_W]);
        end
    end

    // State registers; reset wins over the boundary update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cont    <= '0;
            A       <= '0;
            amostra <= SAMPLE_RST;
        end else begin
            cont    <= cont_d;
            A       <= A_d;
            amostra <= amostra_d;
        end
    end

    assign saida = (cont < amostra);

endmodule

// File: tb/tb_pwm.sv
// Self-checking bench for pwm: two instances (default STEP and STEP=4096 to
// reach the table extremes quickly), a per-period high-time scoreboard and
// direct register probes around resets and boundaries.
module tb_pwm;

    localparam int unsigned PERIOD = 4096;

    logic clk;
    logic rst_n_a;
    logic rst_n_b;
    logic saida_a;
    logic saida_b;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected high time of each full period, one queue per instance.
    int exp_q [2][$];

    pwm u_dut (
        .clk   (clk),
        .rst_n (rst_n_a),
        .saida (saida_a)
    );

    pwm #(.STEP(4096)) u_fast (
        .clk   (clk),
        .rst_n (rst_n_b),
        .saida (saida_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference sine sample straight from the defining formula.
    function automatic int sine_ref(input int k);
        real x;
        x = 2048.0 + 2047.0 * $sin(2.0 * 3.14159265358979 * real'(k) / 64.0);
        return $rtoi(x + 0.5);
    endfunction

    // High time of period j after reset for a given phase step.
    function automatic int exp_high(input int step, input int j);
        int a;
        a = (j * step) % 16384;
        return sine_ref(a / 256);
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: frames periods by cycles since reset, measures high time and
    // checks the high-then-low shape, then pops and compares.
    initial begin
        int  pos    [2];
        int  hi     [2];
        bit  low    [2];
        bit  bad    [2];
        bit  armed  [2];
        logic r     [2];
        logic s     [2];
        int  e;
        for (int i = 0; i < 2; i++) begin
            pos[i] = 0; hi[i] = 0; low[i] = 0; bad[i] = 0; armed[i] = 0;
        end
        forever begin
            @(negedge clk);
            r[0] = rst_n_a; r[1] = rst_n_b;
            s[0] = saida_a; s[1] = saida_b;
            for (int i = 0; i < 2; i++) begin
                if (r[i] === 1'b0) begin
                    armed[i] = 1; pos[i] = 0; hi[i] = 0; low[i] = 0; bad[i] = 0;
                end else if (armed[i]) begin
                    pos[i] = (pos[i] + 1) % PERIOD;
                    if (pos[i] == 0) begin
                        hi[i] = 0; low[i] = 0; bad[i] = 0;
                    end
                end
                if (armed[i]) begin
                    if (s[i] === 1'b1) begin
                        if (low[i]) bad[i] = 1;
                        hi[i]++;
                    end else begin
                        if (s[i] !== 1'b0) bad[i] = 1;
                        low[i] = 1;
                    end
                    if (pos[i] == PERIOD - 1) begin
                        if (exp_q[i].size() == 0) begin
                            check($sformatf("unexpected_period_inst%0d", i), 32'(hi[i]), 32'hFFFF_FFFF);
                        end else begin
                            e = exp_q[i].pop_front();
                            check($sformatf("high_time_inst%0d", i), 32'(hi[i]), 32'(e));
                            check($sformatf("pulse_shape_inst%0d", i), 32'(bad[i]), 32'd0);
                        end
                    end
                end
            end
        end
    end

    // Watchdog.
    initial begin
        #(10 * 80000);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        fork
            // Default STEP = 256.
            begin
                int r;
                repeat (2) @(negedge clk);
                check("rst_cont",    32'(u_dut.cont),    32'd0);
                check("rst_A",       32'(u_dut.A),       32'd0);
                check("rst_amostra", 32'(u_dut.amostra), 32'd2048);
                check("rst_saida",   32'(saida_a),       32'd1);
                #1 rst_n_a = 1'b1;
                for (int j = 0; j < 3; j++) exp_q[0].push_back(exp_high(256, j));
                wait_cycles(PERIOD);
                check("p1_cont",    32'(u_dut.cont),    32'd0);
                check("p1_A",       32'(u_dut.A),       32'd256);
                check("p1_amostra", 32'(u_dut.amostra), 32'd2249);
                wait_cycles(2 * PERIOD);
                r = int'($urandom_range(900, 1100));
                wait_cycles(r);
                check("mid_cont_pre", 32'(u_dut.cont), 32'(r));
                check("mid_A_pre",    32'(u_dut.A),    32'd768);
                #1 rst_n_a = 1'b0;
                @(negedge clk);
                check("mid_rst_cont",    32'(u_dut.cont),    32'd0);
                check("mid_rst_A",       32'(u_dut.A),       32'd0);
                check("mid_rst_amostra", 32'(u_dut.amostra), 32'd2048);
                check("mid_rst_saida",   32'(saida_a),       32'd1);
                #1 rst_n_a = 1'b1;
                for (int j = 0; j < 2; j++) exp_q[0].push_back(exp_high(256, j));
                wait_cycles(2 * PERIOD - 1);
                check("edge_cont_pre", 32'(u_dut.cont), 32'd4095);
                check("edge_A_pre",    32'(u_dut.A),    32'd256);
                #1 rst_n_a = 1'b0;
                @(negedge clk);
                check("edge_rst_cont",    32'(u_dut.cont),    32'd0);
                check("edge_rst_A",       32'(u_dut.A),       32'd0);
                check("edge_rst_amostra", 32'(u_dut.amostra), 32'd2048);
                #1 rst_n_a = 1'b1;
                exp_q[0].push_back(exp_high(256, 0));
                wait_cycles(PERIOD - 1);
            end
            // STEP = 4096: visits the peak, trough and phase wrap.
            begin
                int r;
                repeat (2) @(negedge clk);
                check("f_rst_amostra", 32'(u_fast.amostra), 32'd2048);
                #1 rst_n_b = 1'b1;
                for (int j = 0; j < 5; j++) exp_q[1].push_back(exp_high(4096, j));
                wait_cycles(PERIOD);
                check("f_peak_A",       32'(u_fast.A),       32'd4096);
                check("f_peak_amostra", 32'(u_fast.amostra), 32'd4095);
                wait_cycles(2 * PERIOD);
                check("f_trough_A",       32'(u_fast.A),       32'd12288);
                check("f_trough_amostra", 32'(u_fast.amostra), 32'd1);
                check("f_trough_saida",   32'(saida_b),        32'd1);
                @(negedge clk);
                check("f_trough_saida_low", 32'(saida_b), 32'd0);
                wait_cycles(PERIOD - 1);
                check("f_wrap_A",       32'(u_fast.A),       32'd0);
                check("f_wrap_amostra", 32'(u_fast.amostra), 32'd2048);
                wait_cycles(PERIOD - 1);
                r = int'($urandom_range(1, 4000));
                wait_cycles(r);
                #1 rst_n_b = 1'b0;
                @(negedge clk);
                check("f_rnd_rst_cont", 32'(u_fast.cont), 32'd0);
                check("f_rnd_rst_A",    32'(u_fast.A),    32'd0);
                #1 rst_n_b = 1'b1;
                exp_q[1].push_back(exp_high(4096, 0));
                wait_cycles(PERIOD - 1);
            end
        join
        wait_cycles(2);
        check("queue_drained_inst0", 32'(exp_q[0].size()), 32'd0);
        check("queue_drained_inst1", 32'(exp_q[1].size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
